// File: rtl/cond_status_unit_pkg.sv
// Shared definitions for the condition/status unit: condition-code values,
// flag bit positions inside {N,Z,C,V}, and the condition field width.
package cond_status_unit_pkg;

   localparam int COND_W = 4;

   // Flag bit positions inside the 4-bit status word {N,Z,C,V}
   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   // Condition codes
   localparam logic [COND_W-1:0] COND_EQ = 4'h0;
   localparam logic [COND_W-1:0] COND_NE = 4'h1;
   localparam logic [COND_W-1:0] COND_CS = 4'h2;
   localparam logic [COND_W-1:0] COND_CC = 4'h3;
   localparam logic [COND_W-1:0] COND_MI = 4'h4;
   localparam logic [COND_W-1:0] COND_PL = 4'h5;
   localparam logic [COND_W-1:0] COND_VS = 4'h6;
   localparam logic [COND_W-1:0] COND_VC = 4'h7;
   localparam logic [COND_W-1:0] COND_HI = 4'h8;
   localparam logic [COND_W-1:0] COND_LS = 4'h9;
   localparam logic [COND_W-1:0] COND_GE = 4'hA;
   localparam logic [COND_W-1:0] COND_LT = 4'hB;
   localparam logic [COND_W-1:0] COND_GT = 4'hC;
   localparam logic [COND_W-1:0] COND_LE = 4'hD;
   localparam logic [COND_W-1:0] COND_AL = 4'hE;
   localparam logic [COND_W-1:0] COND_NV = 4'hF;

   // AL and NV ignore the flags, so an in-flight flag write cannot change them
   function automatic logic is_flag_free(input logic [COND_W-1:0] cond);
      return (cond == COND_AL) || (cond == COND_NV);
   endfunction

endpackage

// File: rtl/cond_status_unit_cond_eval.sv
// Combinational condition evaluator: one 4-bit condition code against one
// {N,Z,C,V} flag word, producing a single pass bit.
module cond_eval
   import cond_status_unit_pkg::*;
(
   input  logic [COND_W-1:0] cond,
   input  logic [3:0]        flags,
   output logic              pass
);

   logic n, z, c, v;

   assign n = flags[N_BIT];
   assign z = flags[Z_BIT];
   assign c = flags[C_BIT];
   assign v = flags[V_BIT];

   // Decode the condition code against the flag bits
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_status_unit.sv
// Condition/status unit: holds the {N,Z,C,V} status register and evaluates
// up to LANES condition queries per cycle with one-cycle registered results.
// Optional macro COND_FLAG_FWD_EN: when defined, a same-cycle flag write is
// forwarded into the evaluation and no hazard stall is ever requested; when
// undefined, queries that depend on flags being written this cycle raise
// hazard_stall and are not marked valid.
module cond_status_unit
   import cond_status_unit_pkg::*;
#(
   parameter int         LANES  = 1,
   parameter logic [3:0] SR_RST = 4'b0000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  flag_we,
   input  logic [3:0]            flag_in,
   input  logic [LANES-1:0]      q_valid,
   input  logic [4*LANES-1:0]    q_cond,
   output logic [LANES-1:0]      q_pass,
   output logic [LANES-1:0]      q_out_valid,
   output logic                  hazard_stall,
   output logic [3:0]            sr_out
);

   logic [3:0]       sr;
   logic [3:0]       ef;
   logic [LANES-1:0] lane_pass;
   logic [LANES-1:0] lane_block;

`ifdef COND_FLAG_FWD_EN
   assign ef           = flag_we ? flag_in : sr;
   assign lane_block   = '0;
   assign hazard_stall = 1'b0;
`else
   assign ef = sr;

   // A valid lane reading flags that are being rewritten this cycle is stale
   always_comb begin
      lane_block = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_block[i] = flag_we & q_valid[i] & ~is_flag_free(q_cond[4*i +: 4]);
      end
   end

   assign hazard_stall = ~rst & (|lane_block);
`endif

   assign sr_out = sr;

   // One evaluator per lane, all sharing the effective flags
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      cond_eval u_eval (
         .cond  (q_cond[4*g +: 4]),
         .flags (ef),
         .pass  (lane_pass[g])
      );
   end

   // Status register: loads on an unstalled flag write; flush leaves it alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= SR_RST;
      end else if (flag_we && !stall) begin
         sr <= flag_in;
      end
   end

   // Result registers: flush squashes valids, stall holds, otherwise capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_pass      <= '0;
         q_out_valid <= '0;
      end else if (flush) begin
         q_out_valid <= '0;
      end else if (!stall) begin
         q_out_valid <= q_valid & ~lane_block;
         q_pass      <= q_valid & ~lane_block & lane_pass;
      end
   end

endmodule

// File: doc/cond_status_unit.md
COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 SHALL have parameter LANES, default 1, range 1..4: number of parallel condition queries.
REQ-002 SHALL have parameter SR_RST, default 4'b0000: status register reset value {N,Z,C,V}.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1: pipeline freeze.
REQ-006 SHALL have port flush, input, 1: squash in-flight query results.
REQ-007 SHALL have port flag_we, input, 1: EXE-stage flag write (S bit and instruction valid).
REQ-008 SHALL have port flag_in, input, 4: new flags {N,Z,C,V}, bit3=N, bit0=V.
REQ-009 SHALL have port q_valid, input, LANES: per-lane query valid.
REQ-010 SHALL have port q_cond, input, 4*LANES: lane i condition code in bits [4i+3:4i].
REQ-011 SHALL have port q_pass, output, LANES: registered condition result per lane.
REQ-012 SHALL have port q_out_valid, output, LANES: registered result valid per lane.
REQ-013 SHALL have port hazard_stall, output, 1: request upstream hold for one cycle.
REQ-014 SHALL have port sr_out, output, 4: current status register.

Function
REQ-015 SHALL hold status register SR; on a clock edge with flag_we=1 and stall=0, SR SHALL load flag_in; otherwise SR holds.
REQ-016 SHALL decode codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-017 SHALL evaluate each lane against the effective flags EF (SR, or forwarded value per REQ-026) and register q_pass[i] with one-cycle latency.
REQ-018 SHALL set q_out_valid[i] one cycle after q_valid[i]=1 when no hazard, stall=0 and flush=0.
REQ-019 SHALL hold q_pass and q_out_valid unchanged while stall=1 and flush=0.
REQ-020 SHALL clear all q_out_valid on the edge where flush=1; flush SHALL take priority over stall; flush SHALL NOT affect SR.
REQ-021 SHALL drive q_pass[i]=0 for any lane whose q_valid[i]=0 at capture.
REQ-022 SHALL treat AL and NV as hazard-free; they never assert hazard_stall.

Reset
REQ-023 SHALL on rst=1, immediately and independent of clk, set SR=SR_RST, q_pass=0, q_out_valid=0; hazard_stall=0 while rst=1.
REQ-024 SHALL on rst mid-operation discard any pending flag write and query result.

Configuration
REQ-025 SHALL recognise macro COND_FLAG_FWD_EN.
REQ-026 SHALL, with COND_FLAG_FWD_EN defined, use EF=flag_in when flag_we=1, else SR; hazard_stall SHALL be constant 0.
REQ-027 SHALL, without COND_FLAG_FWD_EN, use EF=SR; hazard_stall SHALL be 1 combinationally whenever flag_we=1 and any valid lane has a code other than E/F; such lanes SHALL not register q_out_valid that cycle.

Structure
REQ-028 SHALL place condition-code localparams (EQ..NV), flag bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0, and the 4-bit condition width in the shared defines package.
REQ-029 SHALL instantiate one combinational sub-module cond_eval (4-bit cond, 4-bit flags -> pass) per lane via generate.

Verification
REQ-030 SHALL cover reset: assert rst with SR=4'b1111 -> sr_out=4'b0000, q_out_valid=0 immediately, before the next clock edge.
REQ-031 SHALL cover full decode: SR swept over all 16 values x all 16 codes, lane 0 -> q_pass matches REQ-016 table one cycle later.
REQ-032 SHALL cover same-cycle write: SR=4'b0000, flag_we=1, flag_in=4'b0100, q_cond=EQ -> FWD: q_pass=1 next cycle; no FWD: hazard_stall=1, q_out_valid=0, query reissued next cycle gives q_pass=1.
REQ-033 SHALL cover stall/flush: result q_pass=1 registered, stall=1 for 3 cycles with flag_we=1 -> outputs and SR held; flush=1 with stall=1 -> q_out_valid=0, SR unchanged.
REQ-034 SHALL cover multi-lane: LANES=4, SR=4'b1001 (N=1,V=1), codes {GE,LT,AL,NV} -> q_pass=4'b0101 (lane0=1, lane1=0, lane2=1, lane3=0).
